multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised next-generation control FSM for the multicycle 16-bit datapath. It decodes `op`/`op_ext`, evaluates branch conditions against the PSR, and sequences fetch, execute, memory and write-back. Compared with the previous controller it adds:
- a ready/request handshake to memory, so fetch, load and store stall on slow memory;
- a parametrised WAIT duration;
- a defined halt for illegal encodings, with an optional trap.

## Interface
- `WAIT_W`, 8: width of the WAIT-instruction counter.
- `WAIT_CYCLES`, 16: cycles spent in WAIT, 1..2^WAIT_W−1.
- `PSR_W`, 5: PSR flag width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 4: instruction [15:12].
- `op_ext` in 4: instruction [7:4].
- `branch_cond` in 4: instruction condition field.
- `PSR` in PSR_W: flags {C,L,F,Z,N}.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `WD_S`, `ALUA_S`, `ALUB_S`, `MEM_S`, `MEM_DATA_S` out 2 each: datapath mux selects.
- `PC_S`, `PC_EN`, `REG_WR_EN`, `INSTR_EN`, `ALU_OUT_EN`, `MEM_REG_EN`, `MEM_WR_S`, `PSR_EN` out 1 each: enables.
- `SE_SIGN` out 1: 1 = sign-extend the immediate, 0 = zero-extend.
- `halted` out 1: FSM is parked in HALT.
- `trap` out 1: datapath loads the trap vector into PC when `trap & PC_EN`.

## Operation

Outputs are combinational from state (Moore), except the memory-qualified enables noted below. Default value of every output is 0, except `SE_SIGN` = 1. After reset the FSM is in FETCH.

State behaviour:
- **FETCH**: `MEM_S`=01, `mem_req`=1, `INSTR_EN`=`mem_ready`. Holds until `mem_ready`, then goes to DECODE.
- **DECODE**: no outputs asserted. Next state by `op`:
  - 0100, by `op_ext`:
    - 0100 → SB_MEM_R
    - 0000 → LB_MEM
    - 1100 → JUMP if the condition is true, else PC_UP
    - 1000 → CALC_RLINK
    - other → illegal
  - 0000 → RTYPE_EX.
  - 1000: `op_ext`=0100 → RTYPE_EX, else ITYPE_EX.
  - 1100 → CALC_DISP if the condition is true, else PC_UP.
  - any other `op` → ITYPE_EX.
- **RTYPE_EX**: `ALU_OUT_EN`=`PSR_EN`=1. Next: `op_ext` 1011 (CMP) → PC_UP; 1111 → WAIT; else WRITE.
- **ITYPE_EX**: `ALUA_S`=10, `ALU_OUT_EN`=`PSR_EN`=1. `SE_SIGN`=0 for `op` 0001/0010/0011, else 1. Next: `op` 1011 → PC_UP; 0111 → SB_MEM_I; else WRITE.
- **WRITE**: `WD_S`=11, `REG_WR_EN`=1. Next: PC_UP.
- **LB_MEM**: `WD_S`=10, `mem_req`=1, `MEM_REG_EN`=`mem_ready`. Holds until `mem_ready`, then LB_LOAD.
- **LB_LOAD**: `WD_S`=10, `REG_WR_EN`=1. Next: PC_UP.
- **SB_MEM_R**: `mem_req`=1, `MEM_WR_S`=`mem_ready`, `MEM_DATA_S`=00. Holds until `mem_ready`, then PC_UP.
- **SB_MEM_I**: same as SB_MEM_R but `MEM_S`=10, `MEM_DATA_S`=01.
- **CALC_DISP**: `ALUA_S`=01, `ALUB_S`=01, `PC_S`=`PC_EN`=1. Next: FETCH.
- **JUMP**: `PC_EN`=1. Next: FETCH.
- **CALC_RLINK**: `ALUA_S`=01, `ALUB_S`=10, `ALU_OUT_EN`=1. Next: WR_RLINK_J.
- **WR_RLINK_J**: `WD_S`=11, `PC_EN`=`REG_WR_EN`=1. Next: FETCH.
- **PC_UP**: `ALUA_S`=01, `ALUB_S`=10, `PC_S`=`PC_EN`=1. Next: FETCH.
- **WAIT**: counter is cleared on entry and counts each cycle. Exit to PC_UP after exactly `WAIT_CYCLES` cycles in WAIT.
- **HALT**: `halted`=1. Absorbing; only `reset` leaves it. Entered from illegal decode and from any unencoded state value.

Condition evaluation (code → true when):
- 0000: Z
- 0001: !Z
- 0010: C
- 0011: !C
- 0100: F
- 0101: !F
- 0110: N
- 0111: !N
- 1000: L
- 1001: !L
- 1110: always
- any other code: false

## Timing
- Instruction latency with `mem_ready` tied high: ALU op 5 cycles (FETCH, DECODE, EX, WRITE, PC_UP); CMP 4; load 5; store 4; taken branch 3; not-taken branch 3; JAL 4; WAIT 4+`WAIT_CYCLES`.
- Each cycle `mem_ready` is low in a memory state adds exactly one cycle.
- `mem_ready` asserted outside a memory state is ignored.
- Write strobes are asserted for exactly one cycle per instruction.
- `reset` sampled high in any state → FETCH on the next edge with all outputs at their defaults. This includes reset mid-stall and reset in HALT. The WAIT counter clears on reset.

## Configuration
- `CTRL_TRAP_EN` defined: an illegal decode goes to TRAP. In TRAP, `trap`=1 and `PC_EN`=1 for one cycle; next state is FETCH.
- `CTRL_TRAP_EN` undefined: no TRAP state exists; `trap` is tied 0 and an illegal decode goes to HALT.

## Structure
- Shared package `ctrl_pkg` holds:
  - state enum (5 bits);
  - opcode/ext constants: RTYPE, LSH, BCOND, OP_EXT, SB, LB, JCOND, JAL, CMP, WA, ANDI, ORI, XORI, SBI;
  - mux-select constants.
- One sub-module, `cond_eval`: combinational condition check, (`branch_cond`, `PSR`) → `take`.

## Test plan
- ADD (`op`=0000, `op_ext`=0101), `mem_ready`=1 → FETCH, DECODE, RTYPE_EX, WRITE, PC_UP; `REG_WR_EN` high exactly one cycle, then FETCH.
- Load (`op`=0100, `op_ext`=0000) with `mem_ready` low 3 cycles in LB_MEM → `MEM_REG_EN` pulses once, on the ready cycle; total 8 cycles.
- Bcond with `branch_cond`=0000: Z=1 → CALC_DISP with `PC_S`=`PC_EN`=1; Z=0 → PC_UP.
- WAIT (`op_ext`=1111) with `WAIT_CYCLES`=16 → exactly 16 cycles in WAIT, then PC_UP.
- `op`=0100, `op_ext`=0001 → `halted`=1 and stays there despite further `mem_ready`; with `CTRL_TRAP_EN` defined → `trap` and `PC_EN` for one cycle, then FETCH.
- `reset` asserted during a FETCH stall → next cycle in FETCH, `INSTR_EN`=0, `SE_SIGN`=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle controller.
// TRAP state exists only when CTRL_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH      = 5'd0,
    S_DECODE     = 5'd1,
    S_RTYPE_EX   = 5'd2,
    S_ITYPE_EX   = 5'd3,
    S_WRITE      = 5'd4,
    S_LB_MEM     = 5'd5,
    S_LB_LOAD    = 5'd6,
    S_SB_MEM_R   = 5'd7,
    S_SB_MEM_I   = 5'd8,
    S_CALC_DISP  = 5'd9,
    S_JUMP       = 5'd10,
    S_CALC_RLINK = 5'd11,
    S_WR_RLINK_J = 5'd12,
    S_PC_UP      = 5'd13,
    S_WAIT       = 5'd14,
    S_HALT       = 5'd15
`ifdef CTRL_TRAP_EN
    ,
    S_TRAP       = 5'd16
`endif
  } state_t;

  localparam logic [3:0] RTYPE  = 4'b0000;
  localparam logic [3:0] LSH    = 4'b1000;
  localparam logic [3:0] BCOND  = 4'b1100;
  localparam logic [3:0] OP_EXT = 4'b0100;
  localparam logic [3:0] SB     = 4'b0100;
  localparam logic [3:0] LB     = 4'b0000;
  localparam logic [3:0] JCOND  = 4'b1100;
  localparam logic [3:0] JAL    = 4'b1000;
  localparam logic [3:0] CMP    = 4'b1011;
  localparam logic [3:0] WA     = 4'b1111;
  localparam logic [3:0] ANDI   = 4'b0001;
  localparam logic [3:0] ORI    = 4'b0010;
  localparam logic [3:0] XORI   = 4'b0011;
  localparam logic [3:0] SBI    = 4'b0111;
  localparam logic [3:0] LSH_R  = 4'b0100;

  localparam logic [1:0] WD_MEM    = 2'b10;
  localparam logic [1:0] WD_ALU    = 2'b11;
  localparam logic [1:0] ALUA_PC   = 2'b01;
  localparam logic [1:0] ALUA_IMM  = 2'b10;
  localparam logic [1:0] ALUB_DISP = 2'b01;
  localparam logic [1:0] ALUB_ONE  = 2'b10;
  localparam logic [1:0] MADDR_PC  = 2'b01;
  localparam logic [1:0] MADDR_ALU = 2'b10;
  localparam logic [1:0] MDATA_REG = 2'b00;
  localparam logic [1:0] MDATA_IMM = 2'b01;

  localparam int PSR_N = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_F = 2;
  localparam int PSR_L = 3;
  localparam int PSR_C = 4;

  function automatic logic is_zext(input logic [3:0] op);
    return (op == ANDI) || (op == ORI) || (op == XORI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between controller and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;

  modport master (output mem_req, input mem_ready);
  modport slave  (input mem_req, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_cond_eval.sv
// Branch condition check of the condition field against PSR flags.
module cond_eval
  import ctrl_pkg::*;
#(
  parameter int PSR_W = 5
) (
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] PSR,
  output logic             take
);

  always_comb begin
    take = 1'b0;
    case (branch_cond)
      4'b0000: take =  PSR[PSR_Z];
      4'b0001: take = !PSR[PSR_Z];
      4'b0010: take =  PSR[PSR_C];
      4'b0011: take = !PSR[PSR_C];
      4'b0100: take =  PSR[PSR_F];
      4'b0101: take = !PSR[PSR_F];
      4'b0110: take =  PSR[PSR_N];
      4'b0111: take = !PSR[PSR_N];
      4'b1000: take =  PSR[PSR_L];
      4'b1001: take = !PSR[PSR_L];
      4'b1110: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle 16-bit datapath controller with memory stalls.
// Define CTRL_TRAP_EN to trap illegal encodings instead of halting.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_W      = 8,
  parameter int WAIT_CYCLES = 16,
  parameter int PSR_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [3:0]       op_ext,
  input  logic [3:0]       branch_cond,
  input  logic [PSR_W-1:0] PSR,
  multicycle_ctrl_if.master mem,
  output logic [1:0]       WD_S,
  output logic [1:0]       ALUA_S,
  output logic [1:0]       ALUB_S,
  output logic [1:0]       MEM_S,
  output logic [1:0]       MEM_DATA_S,
  output logic             PC_S,
  output logic             PC_EN,
  output logic             REG_WR_EN,
  output logic             INSTR_EN,
  output logic             ALU_OUT_EN,
  output logic             MEM_REG_EN,
  output logic             MEM_WR_S,
  output logic             PSR_EN,
  output logic             SE_SIGN,
  output logic             halted,
  output logic             trap
);

`ifdef CTRL_TRAP_EN
  localparam state_t S_ILL = S_TRAP;
`else
  localparam state_t S_ILL = S_HALT;
`endif

  state_t            state;
  state_t            next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              take;
  logic              wait_done;

  cond_eval #(.PSR_W(PSR_W)) u_cond (
    .branch_cond (branch_cond),
    .PSR         (PSR),
    .take        (take)
  );

  assign wait_done = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Held at zero outside WAIT, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    next        = state;
    mem.mem_req = 1'b0;
    WD_S        = 2'b00;
    ALUA_S      = 2'b00;
    ALUB_S      = 2'b00;
    MEM_S       = 2'b00;
    MEM_DATA_S  = 2'b00;
    PC_S        = 1'b0;
    PC_EN       = 1'b0;
    REG_WR_EN   = 1'b0;
    INSTR_EN    = 1'b0;
    ALU_OUT_EN  = 1'b0;
    MEM_REG_EN  = 1'b0;
    MEM_WR_S    = 1'b0;
    PSR_EN      = 1'b0;
    SE_SIGN     = 1'b1;
    halted      = 1'b0;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        MEM_S       = MADDR_PC;
        mem.mem_req = 1'b1;
        INSTR_EN    = mem.mem_ready;
        if (mem.mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_EXT): begin
            unique case (1'b1)
              (op_ext == SB):    next = S_SB_MEM_R;
              (op_ext == LB):    next = S_LB_MEM;
              (op_ext == JCOND): next = take ? S_JUMP : S_PC_UP;
              (op_ext == JAL):   next = S_CALC_RLINK;
              default:           next = S_ILL;
            endcase
          end
          (op == RTYPE): next = S_RTYPE_EX;
          (op == LSH):
            next = (op_ext == LSH_R) ? S_RTYPE_EX : S_ITYPE_EX;
          (op == BCOND): next = take ? S_CALC_DISP : S_PC_UP;
          default:       next = S_ITYPE_EX;
        endcase
      end
      S_RTYPE_EX: begin
        ALU_OUT_EN = 1'b1;
        PSR_EN     = 1'b1;
        unique case (1'b1)
          (op_ext == CMP): next = S_PC_UP;
          (op_ext == WA):  next = S_WAIT;
          default:         next = S_WRITE;
        endcase
      end
      S_ITYPE_EX: begin
        ALUA_S     = ALUA_IMM;
        ALU_OUT_EN = 1'b1;
        PSR_EN     = 1'b1;
        SE_SIGN    = !is_zext(op);
        unique case (1'b1)
          (op == CMP): next = S_PC_UP;
          (op == SBI): next = S_SB_MEM_I;
          default:     next = S_WRITE;
        endcase
      end
      S_WRITE: begin
        WD_S      = WD_ALU;
        REG_WR_EN = 1'b1;
        next      = S_PC_UP;
      end
      S_LB_MEM: begin
        WD_S        = WD_MEM;
        mem.mem_req = 1'b1;
        MEM_REG_EN  = mem.mem_ready;
        if (mem.mem_ready) next = S_LB_LOAD;
      end
      S_LB_LOAD: begin
        WD_S      = WD_MEM;
        REG_WR_EN = 1'b1;
        next      = S_PC_UP;
      end
      S_SB_MEM_R: begin
        mem.mem_req = 1'b1;
        MEM_WR_S    = mem.mem_ready;
        MEM_DATA_S  = MDATA_REG;
        if (mem.mem_ready) next = S_PC_UP;
      end
      S_SB_MEM_I: begin
        mem.mem_req = 1'b1;
        MEM_WR_S    = mem.mem_ready;
        MEM_S       = MADDR_ALU;
        MEM_DATA_S  = MDATA_IMM;
        if (mem.mem_ready) next = S_PC_UP;
      end
      S_CALC_DISP: begin
        ALUA_S = ALUA_PC;
        ALUB_S = ALUB_DISP;
        PC_S   = 1'b1;
        PC_EN  = 1'b1;
        next   = S_FETCH;
      end
      S_JUMP: begin
        PC_EN = 1'b1;
        next  = S_FETCH;
      end
      S_CALC_RLINK: begin
        ALUA_S     = ALUA_PC;
        ALUB_S     = ALUB_ONE;
        ALU_OUT_EN = 1'b1;
        next       = S_WR_RLINK_J;
      end
      S_WR_RLINK_J: begin
        WD_S      = WD_ALU;
        PC_EN     = 1'b1;
        REG_WR_EN = 1'b1;
        next      = S_FETCH;
      end
      S_PC_UP: begin
        ALUA_S = ALUA_PC;
        ALUB_S = ALUB_ONE;
        PC_S   = 1'b1;
        PC_EN  = 1'b1;
        next   = S_FETCH;
      end
      S_WAIT: begin
        if (wait_done) next = S_PC_UP;
      end
      S_HALT: begin
        halted = 1'b1;
        next   = S_HALT;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        trap  = 1'b1;
        PC_EN = 1'b1;
        next  = S_FETCH;
      end
`endif
      default: next = S_HALT;
    endcase
  end

endmodule
